// File: rtl/control_sequencer.sv
// control_sequencer: hardwired fetch/execute control-step sequencer with memory-ready waits and HALT parking.
module control_sequencer (
    input  logic        clock,
    input  logic        clear,
    input  logic [31:0] IR,
    input  logic        mem_ready,
    input  logic        CON_FF,
    output logic        PC_out,
    output logic        PC_in,
    output logic        IncPC,
    output logic        MAR_in,
    output logic        MDR_in,
    output logic        MDR_out,
    output logic        IR_in,
    output logic        Y_in,
    output logic        Z_in,
    output logic        Zlow_out,
    output logic        C_out,
    output logic        Read,
    output logic        Write,
    output logic        CON_in,
    output logic        CON_out,
    output logic        G_ra,
    output logic        G_rb,
    output logic        G_rc,
    output logic        R_in,
    output logic        R_out,
    output logic        BA_out,
    output logic [4:0]  alu_op,
    output logic        run
);
    typedef enum logic [3:0] {
        S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_t;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_ORI  = 5'b01101;
    localparam logic [4:0] OP_BR   = 5'b10010;
    localparam logic [4:0] OP_HALT = 5'b11010;

    state_t     state_q, state_d;
    logic [4:0] op_q, op_d;
    logic [4:0] ir_op;
    logic       ir_exec, ir_halt;
    logic       is_r, is_imm, is_ldi, is_ld, is_st, is_br;
    logic       unused_ir;

    assign ir_op     = IR[31:27];
    assign unused_ir = ^IR[26:0];
    assign ir_exec   = (ir_op <= OP_ORI) || (ir_op == OP_BR);
    assign ir_halt   = ir_op == OP_HALT;

    assign is_r   = (op_q >= OP_ADD) && (op_q <= 5'b01010);
    assign is_imm = (op_q >= 5'b01011) && (op_q <= OP_ORI);
    assign is_ldi = op_q == OP_LDI;
    assign is_ld  = op_q == OP_LD;
    assign is_st  = op_q == OP_ST;
    assign is_br  = op_q == OP_BR;

    // Opcode is captured while leaving T2 so execute states never look at IR again.
    assign op_d = (state_q == S_T2) ? ir_op : op_q;

    always_ff @(posedge clock) begin
        if (!clear) begin
            state_q <= S_RESET;
            op_q    <= 5'd0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RESET: state_d = S_T0;
            S_T0:    state_d = S_T1;
            S_T1:    state_d = mem_ready ? S_T2 : S_T1;
            S_T2:    state_d = ir_halt ? S_HALT : (ir_exec ? S_T3 : S_T0);
            S_T3:    state_d = S_T4;
            S_T4:    state_d = S_T5;
            S_T5:    state_d = (is_ld || is_st || is_br) ? S_T6 : S_T0;
            S_T6:    state_d = is_br ? S_T0 : ((is_st || mem_ready) ? S_T7 : S_T6);
            S_T7:    state_d = (is_ld || mem_ready) ? S_T0 : S_T7;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_RESET;
        endcase
    end

    always_comb begin
        PC_out   = 1'b0;
        PC_in    = 1'b0;
        IncPC    = 1'b0;
        MAR_in   = 1'b0;
        MDR_in   = 1'b0;
        MDR_out  = 1'b0;
        IR_in    = 1'b0;
        Y_in     = 1'b0;
        Z_in     = 1'b0;
        Zlow_out = 1'b0;
        C_out    = 1'b0;
        Read     = 1'b0;
        Write    = 1'b0;
        CON_in   = 1'b0;
        CON_out  = 1'b0;
        G_ra     = 1'b0;
        G_rb     = 1'b0;
        G_rc     = 1'b0;
        R_in     = 1'b0;
        R_out    = 1'b0;
        BA_out   = 1'b0;
        alu_op   = 5'd0;
        run      = (state_q != S_RESET) && (state_q != S_HALT);
        case (state_q)
            S_T0: begin
                PC_out = 1'b1;
                MAR_in = 1'b1;
                IncPC  = 1'b1;
            end
            S_T1: begin
                Read   = 1'b1;
                MDR_in = 1'b1;
            end
            S_T2: begin
                MDR_out = 1'b1;
                IR_in   = 1'b1;
            end
            S_T3: begin
                G_ra   = is_br;
                CON_in = is_br;
                G_rb   = !is_br;
                Y_in   = !is_br;
                BA_out = is_ldi || is_ld || is_st;
                R_out  = 1'b1;
            end
            S_T4: begin
                PC_out = is_br;
                Y_in   = is_br;
                Z_in   = !is_br;
                G_rc   = is_r;
                R_out  = is_r;
                C_out  = !is_br && !is_r;
                alu_op = is_br ? 5'd0 : ((is_r || is_imm) ? op_q : OP_ADD);
            end
            S_T5: begin
                C_out    = is_br;
                Z_in     = is_br;
                alu_op   = is_br ? OP_ADD : 5'd0;
                Zlow_out = !is_br;
                MAR_in   = is_ld || is_st;
                G_ra     = !is_br && !is_ld && !is_st;
                R_in     = !is_br && !is_ld && !is_st;
            end
            S_T6: begin
                CON_out  = is_br;
                PC_in    = is_br && CON_FF;
                Zlow_out = is_br && CON_FF;
                Read     = is_ld;
                MDR_in   = is_ld || is_st;
                G_ra     = is_st;
                R_out    = is_st;
            end
            S_T7: begin
                MDR_out = is_ld;
                G_ra    = is_ld;
                R_in    = is_ld;
                Write   = is_st;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: per-instruction expected strobe traces with randomized opcodes, waits and don't-care inputs.
module tb_control_sequencer;
    logic        clock, clear, mem_ready, CON_FF;
    logic [31:0] IR;
    logic        PC_out, PC_in, IncPC, MAR_in, MDR_in, MDR_out, IR_in, Y_in, Z_in, Zlow_out;
    logic        C_out, Read, Write, CON_in, CON_out, G_ra, G_rb, G_rc, R_in, R_out, BA_out, run;
    logic [4:0]  alu_op;
    logic [26:0] obs;

    control_sequencer dut (
        .clock(clock), .clear(clear), .IR(IR), .mem_ready(mem_ready), .CON_FF(CON_FF),
        .PC_out(PC_out), .PC_in(PC_in), .IncPC(IncPC), .MAR_in(MAR_in), .MDR_in(MDR_in),
        .MDR_out(MDR_out), .IR_in(IR_in), .Y_in(Y_in), .Z_in(Z_in), .Zlow_out(Zlow_out),
        .C_out(C_out), .Read(Read), .Write(Write), .CON_in(CON_in), .CON_out(CON_out),
        .G_ra(G_ra), .G_rb(G_rb), .G_rc(G_rc), .R_in(R_in), .R_out(R_out), .BA_out(BA_out),
        .alu_op(alu_op), .run(run)
    );

    assign obs = {PC_out, PC_in, IncPC, MAR_in, MDR_in, MDR_out, IR_in, Y_in, Z_in, Zlow_out,
                  C_out, Read, Write, CON_in, CON_out, G_ra, G_rb, G_rc, R_in, R_out, BA_out,
                  run, alu_op};

    localparam logic [26:0] PCO  = 27'h1 << 26, PCI  = 27'h1 << 25, INC  = 27'h1 << 24;
    localparam logic [26:0] MARI = 27'h1 << 23, MDRI = 27'h1 << 22, MDRO = 27'h1 << 21;
    localparam logic [26:0] IRI  = 27'h1 << 20, YI   = 27'h1 << 19, ZI   = 27'h1 << 18;
    localparam logic [26:0] ZLO  = 27'h1 << 17, CO   = 27'h1 << 16, RD   = 27'h1 << 15;
    localparam logic [26:0] WR   = 27'h1 << 14, CONI = 27'h1 << 13, CONO = 27'h1 << 12;
    localparam logic [26:0] GRA  = 27'h1 << 11, GRB  = 27'h1 << 10, GRC  = 27'h1 << 9;
    localparam logic [26:0] RI   = 27'h1 << 8,  RO   = 27'h1 << 7,  BA   = 27'h1 << 6;
    localparam logic [26:0] RN   = 27'h1 << 5;

    typedef struct packed {
        logic [26:0] exp;
        logic        mr;
        logic        cf;
        logic        late;
    } step_t;

    step_t      q[$];
    logic       late_f;
    logic [4:0] cur_op;
    int         compared = 0;
    int         mismatched = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    function automatic logic [26:0] alu(input logic [4:0] op);
        return {22'd0, op};
    endfunction

    task automatic add(input logic [26:0] e, input logic mr, input logic cf);
        step_t s;
        s.exp  = e;
        s.mr   = mr;
        s.cf   = cf;
        s.late = late_f;
        q.push_back(s);
    endtask

    // Expected per-cycle outputs of one instruction, from T0 up to (not including) the next T0.
    task automatic gen(input logic [4:0] op, input logic con, input int w1, input int w6);
        q.delete();
        late_f = 1'b0;
        add(RN | PCO | MARI | INC, rb(), rb());
        repeat (w1) add(RN | RD | MDRI, 1'b0, rb());
        add(RN | RD | MDRI, 1'b1, rb());
        add(RN | MDRO | IRI, rb(), rb());
        late_f = 1'b1;
        if (op == 5'd26) begin
            repeat (20) add(27'd0, rb(), rb());
        end else if (op >= 5'd3 && op <= 5'd13) begin
            add(RN | GRB | RO | YI, rb(), rb());
            add(RN | ZI | ((op <= 5'd10) ? (GRC | RO) : CO) | alu(op), rb(), rb());
            add(RN | ZLO | GRA | RI, rb(), rb());
        end else if (op <= 5'd2) begin
            add(RN | GRB | RO | BA | YI, rb(), rb());
            add(RN | CO | ZI | alu(5'd3), rb(), rb());
            if (op == 5'd1) add(RN | ZLO | GRA | RI, rb(), rb());
            else begin
                add(RN | ZLO | MARI, rb(), rb());
                if (op == 5'd0) begin
                    repeat (w6) add(RN | RD | MDRI, 1'b0, rb());
                    add(RN | RD | MDRI, 1'b1, rb());
                    add(RN | MDRO | GRA | RI, rb(), rb());
                end else begin
                    add(RN | GRA | RO | MDRI, rb(), rb());
                    repeat (w6) add(RN | WR, 1'b0, rb());
                    add(RN | WR, 1'b1, rb());
                end
            end
        end else if (op == 5'd18) begin
            add(RN | GRA | RO | CONI, rb(), rb());
            add(RN | PCO | YI, rb(), rb());
            add(RN | CO | ZI | alu(5'd3), rb(), rb());
            add(RN | CONO | (con ? (PCI | ZLO) : 27'd0), rb(), con);
        end
    endtask

    task automatic chk(input string tag, input logic [26:0] e);
        compared++;
        assert (obs === e) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, e);
        end
    endtask

    task automatic run_trace(input string tag, input int n);
        for (int i = 0; i < n && i < q.size(); i++) begin
            @(negedge clock);
            mem_ready = q[i].mr;
            CON_FF    = q[i].cf;
            IR        = q[i].late ? $urandom : {cur_op, 27'($urandom)};
            #1 chk($sformatf("%s[%0d]", tag, i), q[i].exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        clear     = 1'b0;
        mem_ready = rb();
        @(negedge clock);
        mem_ready = rb();
        #1 chk("reset", 27'd0);
        clear = 1'b1;
        #1 chk("reset_exit", 27'd0);
    endtask

    task automatic exec(input string tag, input logic [4:0] op, input logic con, input int w1, input int w6);
        cur_op = op;
        gen(op, con, w1, w6);
        run_trace(tag, q.size());
        if (op == 5'd26) do_reset();
    endtask

    initial begin
        clear     = 1'b0;
        IR        = 32'd0;
        mem_ready = 1'b0;
        CON_FF    = 1'b0;
        cur_op    = 5'd0;
        late_f    = 1'b0;
        do_reset();
        exec("add", 5'd3, 1'b0, 0, 0);
        exec("ld_wait3", 5'd0, 1'b0, 0, 3);
        exec("st_wait2", 5'd2, 1'b0, 1, 2);
        exec("br_con0", 5'd18, 1'b0, 0, 0);
        exec("br_con1", 5'd18, 1'b1, 0, 0);
        exec("halt", 5'd26, 1'b0, 0, 0);
        exec("nop31", 5'd31, 1'b0, 0, 0);
        exec("ldi", 5'd1, 1'b0, 2, 0);
        exec("andi", 5'd12, 1'b0, 0, 0);
        // Abort an ld while it is waiting in T6, then confirm a clean restart.
        cur_op = 5'd0;
        gen(5'd0, 1'b0, 0, 3);
        run_trace("ld_abort", 7);
        do_reset();
        exec("after_abort", 5'd7, 1'b0, 0, 0);
        for (int k = 0; k < 80; k++) begin
            logic [4:0] op;
            op = 5'($urandom_range(0, 31));
            exec($sformatf("rand%0d_op%0d", k, op), op, rb(), $urandom_range(0, 2), $urandom_range(0, 2));
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/control_sequencer.md
# control_sequencer

Hardwired control-step sequencer for the 32-bit datapath. Walks each instruction through fetch (T0–T2) and execute (T3–T7) states and drives the bus and register-load strobes. It also supplies G_ra/G_rb/G_rc/R_in/R_out/BA_out/CON_out to the select-and-encode stage that turns IR fields into per-register strobes. It waits on memory through a ready handshake, and parks in HALT until reset.

## Interface
- No parameters; opcode field is fixed at IR[31:27].
- clock  in  1  system clock; all state changes on rising edge.
- clear  in  1  synchronous, active-low reset; sampled on rising edge of clock.
- IR  in  32  instruction register contents; opcode = IR[31:27], stable from end of T2.
- mem_ready  in  1  memory done; completes the pending Read or Write on the edge where it is 1.
- CON_FF  in  1  branch-condition flip-flop output.
- PC_out, PC_in, IncPC, MAR_in, MDR_in, MDR_out, IR_in, Y_in, Z_in, Zlow_out, C_out, Read, Write, CON_in, CON_out  out  1 each  datapath strobes.
- G_ra, G_rb, G_rc, R_in, R_out, BA_out  out  1 each  register-select controls to the select/encode stage.
- alu_op  out  5  ALU operation; the opcode value, or 00011 (add) for address/offset adds.
- run  out  1  1 while executing; 0 in RESET and HALT.

## Operation
- States: RESET, T0–T7, HALT. Outputs are Moore-decoded from state plus the latched opcode. Any strobe not listed for a state is 0.
- RESET: all outputs 0. Entered on any edge with clear=0, from any state. The clear=0 case has priority over every other transition. Exit to T0 on first edge with clear=1.
- Fetch:
  - T0: PC_out, MAR_in, IncPC.
  - T1: Read, MDR_in; stays in T1 until mem_ready=1.
  - T2: MDR_out, IR_in.
- The opcode is latched at the T2→T3 edge (for nop/halt, at T2 exit).
- R-type, opcodes 00011–01010:
  - T3: G_rb, R_out, Y_in.
  - T4: G_rc, R_out, Z_in, alu_op=opcode.
  - T5: Zlow_out, G_ra, R_in → T0.
- Immediate, addi/andi/ori (01011–01101):
  - T3: G_rb, R_out, Y_in.
  - T4: C_out, Z_in, alu_op=opcode.
  - T5: Zlow_out, G_ra, R_in → T0.
- ldi (00001):
  - T3: G_rb, R_out, BA_out, Y_in.
  - T4: C_out, Z_in, alu_op=00011.
  - T5: Zlow_out, G_ra, R_in → T0.
- ld (00000):
  - T3/T4: as ldi.
  - T5: Zlow_out, MAR_in.
  - T6: Read, MDR_in; wait for mem_ready.
  - T7: MDR_out, G_ra, R_in → T0.
- st (00010):
  - T3/T4: as ldi.
  - T5: Zlow_out, MAR_in.
  - T6: G_ra, R_out, MDR_in (Read=0, so MDR loads from the bus).
  - T7: Write; wait for mem_ready → T0.
- branch (10010):
  - T3: G_ra, R_out, CON_in.
  - T4: PC_out, Y_in.
  - T5: C_out, Z_in, alu_op=00011.
  - T6: CON_out. PC_in and Zlow_out are asserted only if CON_FF=1 → T0.
- nop (11001) and every undefined opcode: T2 → T0.
- halt (11010): T2 → HALT. HALT holds, all outputs 0, run=0, until clear=0.

## Timing
- Reset value of every output is 0, including run. run=1 in T0–T7.
- Zero-wait cycle counts, counted T0 to the next T0: R-type/imm/ldi 6, branch 7, ld 8, st 8, nop 3.
- Each cycle mem_ready is 0 in T1, T6(ld) or T7(st) adds one cycle. Read/Write and MDR_in stay asserted throughout the wait.
- mem_ready is ignored outside those wait states.
- clear=0 during a memory wait aborts it: Read/Write drop to 0 on that edge.
- CON_FF is sampled combinationally in T6 of a branch only.

## Test plan
- clear=0 for 2 cycles mid-ld (in T6) → next cycle RESET, all outputs 0; clear=1 → T0 with PC_out=MAR_in=IncPC=1, run=1.
- IR opcode 00011 (add), mem_ready tied 1 → states T0,T1,T2,T3,T4,T5,T0 (6 cycles); alu_op=00011 in T4; G_ra&R_in only in T5.
- ld with mem_ready low 3 cycles in T6 → Read=MDR_in=1 for 4 cycles, total 11 cycles; T7 asserts MDR_out, G_ra, R_in.
- st → T6 shows G_ra, R_out, MDR_in with Read=0; T7 Write held until mem_ready=1.
- branch with CON_FF=0 then 1 → T6 CON_out=1 both times; PC_in and Zlow_out equal 1 only in the second run.
- halt (11010) → HALT after T2, run=0, state frozen 20 cycles with mem_ready toggling; opcode 11111 → T2 → T0 (nop).
